// File: rtl/proc_fetch_unit.sv
// Instruction fetch stage: issues PC-ordered imem requests, tags each with an epoch,
// buffers responses that decode cannot take yet and feeds the F/D register.
module proc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_F,
    input  logic        redirect_val,
    input  logic [31:0] redirect_pc,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_addr,
    input  logic        imemresp_val,
    input  logic [31:0] imemresp_data,
    output logic        val_D,
    output logic [31:0] inst_D,
    output logic [31:0] pc_D
);

    typedef struct packed {
        logic        epoch;
        logic [31:0] pc;
    } tag_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } ibuf_t;

    logic [31:0] fetch_pc;
    logic        epoch;

    tag_t        tag_q [2];
    logic        tag_rd, tag_wr;
    logic [1:0]  tag_cnt;

    ibuf_t       buf_q [2];
    logic        buf_rd, buf_wr;
    logic [1:0]  buf_cnt;

    logic [2:0]  occ;
    logic        req_fire;
    logic        resp_pop;
    logic        resp_live;
    logic        bypass;
    logic        buf_enq;
    logic        buf_deq;
    tag_t        tag_head;
    ibuf_t       buf_head;

    // Occupancy caps outstanding + buffered at 2, so neither FIFO can overflow.
    assign occ          = {1'b0, tag_cnt} + {1'b0, buf_cnt};
    assign imemreq_val  = !rst && (occ < 3'd2) && !redirect_val;
    assign imemreq_addr = fetch_pc;
    assign req_fire     = imemreq_val && imemreq_rdy;

    assign tag_head  = tag_q[tag_rd];
    assign buf_head  = buf_q[buf_rd];
    // A response with no tag outstanding is ignored entirely.
    assign resp_pop  = imemresp_val && (tag_cnt != 2'd0);
    assign resp_live = resp_pop && (tag_head.epoch == epoch) && !redirect_val;
    assign buf_deq   = !stall_F && (buf_cnt != 2'd0) && !redirect_val;
    assign bypass    = resp_live && (buf_cnt == 2'd0) && !stall_F;
    assign buf_enq   = resp_live && !bypass;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            epoch    <= 1'b0;
        end else if (redirect_val) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            epoch    <= ~epoch;
        end else if (req_fire) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Tag FIFO keeps draining across redirects; stale entries are dropped on return.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q[0] <= '0;
            tag_q[1] <= '0;
            tag_rd   <= 1'b0;
            tag_wr   <= 1'b0;
            tag_cnt  <= 2'd0;
        end else begin
            if (req_fire) begin
                tag_q[tag_wr].epoch <= epoch;
                tag_q[tag_wr].pc    <= fetch_pc;
                tag_wr              <= ~tag_wr;
            end
            if (resp_pop)
                tag_rd <= ~tag_rd;
            tag_cnt <= tag_cnt + {1'b0, req_fire} - {1'b0, resp_pop};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q[0] <= '0;
            buf_q[1] <= '0;
            buf_rd   <= 1'b0;
            buf_wr   <= 1'b0;
            buf_cnt  <= 2'd0;
        end else if (redirect_val) begin
            buf_rd   <= 1'b0;
            buf_wr   <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            if (buf_enq) begin
                buf_q[buf_wr].inst <= imemresp_data;
                buf_q[buf_wr].pc   <= tag_head.pc;
                buf_wr             <= ~buf_wr;
            end
            if (buf_deq)
                buf_rd <= ~buf_rd;
            buf_cnt <= buf_cnt + {1'b0, buf_enq} - {1'b0, buf_deq};
        end
    end

    // Buffered instructions are older than any arriving response, so they go first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_D  <= 1'b0;
            inst_D <= 32'd0;
            pc_D   <= 32'd0;
        end else if (redirect_val) begin
            val_D  <= 1'b0;
        end else if (!stall_F) begin
            if (buf_deq) begin
                val_D  <= 1'b1;
                inst_D <= buf_head.inst;
                pc_D   <= buf_head.pc;
            end else if (bypass) begin
                val_D  <= 1'b1;
                inst_D <= imemresp_data;
                pc_D   <= tag_head.pc;
            end else begin
                val_D  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/proc_fetch_unit.md
PROC_FETCH_UNIT -- requirements
Module: proc_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000200, the address of the first fetch after reset.
REQ-002 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have port stall_F  in  1  from the pipeline control: hold the F/D register.
REQ-005 SHALL have port redirect_val  in  1  redirect request from a jal, jr or taken-bne resolution.
REQ-006 SHALL have port redirect_pc  in  32  redirect target address.
REQ-007 SHALL have port imemreq_val  out  1  instruction-memory request valid.
REQ-008 SHALL have port imemreq_rdy  in  1  instruction-memory request ready.
REQ-009 SHALL have port imemreq_addr  out  32  request address (the current fetch PC).
REQ-010 SHALL have port imemresp_val  in  1  response valid; always accepted, no ready signal.
REQ-011 SHALL have port imemresp_data  in  32  response instruction word.
REQ-012 SHALL have port val_D  out  1  the F/D register holds a valid instruction.
REQ-013 SHALL have port inst_D  out  32  instruction word presented to decode.
REQ-014 SHALL have port pc_D  out  32  PC of inst_D.

Function
REQ-015 SHALL keep fetch_pc, a 2-entry tag FIFO of {epoch, pc} for outstanding requests, a 2-entry instruction buffer of {inst, pc}, and a 1-bit epoch.
REQ-016 SHALL define occupancy as (outstanding requests + buffer entries), range 0..2.
REQ-017 SHALL assert imemreq_val when not in reset, occupancy < 2, and redirect_val = 0.
REQ-018 SHALL drive imemreq_addr = fetch_pc.
REQ-019 SHALL, on a request fire (val & rdy), push {epoch, fetch_pc} into the tag FIFO and set fetch_pc to fetch_pc + 4 (modulo 2^32; 0xFFFFFFFC wraps to 0).
REQ-020 SHALL hold imemreq_addr stable while imemreq_val = 1 and imemreq_rdy = 0.
REQ-021 SHALL, on imemresp_val, pop the tag FIFO and discard the response when its tag epoch differs from the current epoch.
REQ-022 SHALL, when a current-epoch response arrives, the buffer is empty, and stall_F = 0, bypass it into the F/D register (val_D = 1 next cycle); otherwise it SHALL enqueue it into the buffer.
REQ-023 SHALL, when stall_F = 0 and the buffer is non-empty, load the buffer head into the F/D register and dequeue it; with stall_F = 0 and nothing available, val_D SHALL become 0.
REQ-024 SHALL hold val_D, inst_D and pc_D unchanged while stall_F = 1 and redirect_val = 0.
REQ-025 SHALL, on redirect_val = 1 (priority over stall_F, responses and requests):
- set fetch_pc to {redirect_pc[31:2], 2'b00};
- toggle epoch;
- flush the buffer;
- clear val_D on the next edge.
Tag-FIFO entries remain, to be popped and discarded as they return.
REQ-026 SHALL never overflow the buffer or tag FIFO (guaranteed by REQ-017); a response with an empty tag FIFO is an environment error and SHALL be ignored.
REQ-027 SHALL provide full throughput: with a 1-cycle memory and no stalls, one instruction per cycle reaches val_D.

Reset
REQ-028 SHALL, while rst = 1:
- set fetch_pc to RESET_PC;
- set epoch, outstanding count and buffer count to 0;
- set val_D to 0, inst_D to 0 and pc_D to 0;
- hold imemreq_val at 0.
REQ-029 SHALL, on reset asserted mid-operation, discard all in-flight requests and buffered instructions, with no later response reaching D.
REQ-030 SHALL issue its first request (addr RESET_PC) in the first cycle after rst deasserts.

Verification
REQ-031 Bench SHALL cover: reset release, 1-cycle memory, no stall -> addrs 0x200, 0x204, 0x208 on consecutive cycles; val_D = 1 from cycle 3 with pc_D 0x200, 0x204, 0x208.
REQ-032 Bench SHALL cover: imemreq_rdy = 0 for 3 cycles -> imemreq_addr held at 0x200 and no fire; fetch proceeds after rdy = 1.
REQ-033 Bench SHALL cover: stall_F = 1 for 2 cycles with 2 requests outstanding -> inst_D/pc_D frozen, imemreq_val = 0 once occupancy = 2, no instruction lost or duplicated after release.
REQ-034 Bench SHALL cover: redirect_val = 1 with redirect_pc = 0x00000302 while 2 requests are in flight -> next addr 0x300, both stale responses dropped, next val_D = 1 has pc_D = 0x300.
REQ-035 Bench SHALL cover: redirect_val and stall_F asserted together -> val_D = 0 next cycle.
REQ-036 Bench SHALL cover: redirect to 0xFFFFFFFC -> following fetch addr 0x00000000; rst pulsed mid-stream -> fetch restarts at 0x200 and no pre-reset response appears on val_D.
